// File: rtl/z80_bus_pkg.sv
// Shared types for the tv80s memory-port arbiter: bus ownership states and
// default address/data widths.
package z80_bus_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_CPU,
    ST_REQ,
    ST_DMA,
    ST_RELEASE
  } bus_state_t;

endpackage

// File: rtl/z80_bus_mux.sv
// Memory-port mux: steers either the CPU or the DMA address/data/strobe set
// onto the single-port memory.
module z80_bus_mux #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              sel_dma,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);

  assign mem_addr  = sel_dma ? dma_addr  : cpu_addr;
  assign mem_wdata = sel_dma ? dma_wdata : cpu_wdata;
  assign mem_we    = sel_dma ? dma_we    : cpu_we;

endmodule

// File: rtl/z80_dma_arbiter.sv
// Shares the 64K memory between the tv80s CPU and one DMA requester using the
// busrq_n/busak_n handshake, with bounded bursts and a post-release holdoff.
module z80_dma_arbiter
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 16,
  parameter int HOLDOFF   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_mreq_n,
  input  logic              cpu_wr_n,
  input  logic              cpu_busak_n,
  output logic              cpu_busrq_n,
  output logic [DATA_W-1:0] cpu_di,
  input  logic              dma_req,
  input  logic              dma_valid,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  bus_state_t  state;
  logic [BW-1:0] beat_cnt;
  logic [HW-1:0] hold_cnt;

  logic accept;
  logic sel_dma;
  logic cpu_we;
  logic dma_we_eff;

  // A beat presented while reset is high is never accepted, so nothing
  // reaches memory and no read completion is scheduled.
  assign accept     = (state == ST_DMA) && dma_ready && dma_valid && !reset;
  assign sel_dma    = (state == ST_DMA) || (state == ST_RELEASE);
  assign cpu_we     = !cpu_mreq_n && !cpu_wr_n;
  assign dma_we_eff = accept && dma_we;

  assign cpu_di    = mem_rdata;
  assign dma_rdata = mem_rdata;

  z80_bus_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .sel_dma   (sel_dma),
    .cpu_addr  (cpu_a),
    .cpu_wdata (cpu_do),
    .cpu_we    (cpu_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_we    (dma_we_eff),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_CPU;
      cpu_busrq_n <= 1'b1;
      dma_ready   <= 1'b0;
      dma_rvalid  <= 1'b0;
      dma_grant   <= 1'b0;
      beat_cnt    <= '0;
      hold_cnt    <= '0;
    end else begin
      dma_rvalid <= accept && !dma_we;
      case (state)
        ST_CPU: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
          if (dma_req && hold_cnt == '0) begin
            state       <= ST_REQ;
            cpu_busrq_n <= 1'b0;
          end
        end
        ST_REQ: begin
          if (!cpu_busak_n) begin
            state     <= ST_DMA;
            dma_ready <= 1'b1;
            dma_grant <= 1'b1;
            beat_cnt  <= '0;
          end else if (!dma_req) begin
            state       <= ST_RELEASE;
            cpu_busrq_n <= 1'b1;
          end
        end
        ST_DMA: begin
          if (accept) beat_cnt <= beat_cnt + 1'b1;
          // The beat that reaches MAX_BURST still completes this cycle.
          if (!dma_req || (accept && beat_cnt == BW'(MAX_BURST - 1))) begin
            state       <= ST_RELEASE;
            dma_ready   <= 1'b0;
            dma_grant   <= 1'b0;
            cpu_busrq_n <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cpu_busak_n) begin
            state    <= ST_CPU;
            hold_cnt <= HW'(HOLDOFF);
          end
        end
        default: state <= ST_CPU;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_dma_arbiter.sv
// Self-checking bench for z80_dma_arbiter: the bench plays the CPU handshake and
// the DMA requester, and models the 1-cycle-latency memory.
module tb_z80_dma_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int HO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_do;
  logic          cpu_mreq_n, cpu_wr_n, cpu_busak_n;
  logic          cpu_busrq_n;
  logic [DW-1:0] cpu_di;
  logic          dma_req, dma_valid, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ready, dma_rvalid, dma_grant;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata = '0;

  z80_dma_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .HOLDOFF(HO)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_mreq_n(cpu_mreq_n), .cpu_wr_n(cpu_wr_n),
    .cpu_busak_n(cpu_busak_n), .cpu_busrq_n(cpu_busrq_n), .cpu_di(cpu_di),
    .dma_req(dma_req), .dma_valid(dma_valid), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ready(dma_ready),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_grant(dma_grant),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  bit [7:0] mem [65536];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Read scoreboard: expected data and the cycle the beat was accepted.
  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rd_exp_t;
  rd_exp_t rq[$];

  always @(negedge clk) begin : rd_mon
    rd_exp_t e;
    if (dma_rvalid) begin
      if (rq.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = rq.pop_front();
        check("rdata", dma_rdata, e.data);
        check("rvalid_latency", cyc, e.cyc + 1);
      end
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        mreq_n, wr_n, busak_n;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_we;
  } vec_t;
  vec_t vt[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_mreq_n = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  task automatic dma_beat(input logic we, input logic [15:0] a, input logic [7:0] d);
    dma_valid = 1'b1;
    dma_we    = we;
    dma_addr  = a;
    dma_wdata = d;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int idx;
    int hcnt;

    vt[0] = '{16'h0000, 8'hdd, 1'b0, 1'b1, 1'b1, 16'h0000, 8'hdd, 1'b0};
    vt[1] = '{16'hef75, 8'h17, 1'b0, 1'b0, 1'b1, 16'hef75, 8'h17, 1'b1};
    vt[2] = '{16'h0003, 8'h33, 1'b0, 1'b0, 1'b1, 16'h0003, 8'h33, 1'b1};
    vt[3] = '{16'h1234, 8'h55, 1'b1, 1'b0, 1'b1, 16'h1234, 8'h55, 1'b0};
    vt[4] = '{16'hef76, 8'h0b, 1'b0, 1'b1, 1'b0, 16'hef76, 8'h0b, 1'b0};
    vt[5] = '{16'habcd, 8'h9e, 1'b1, 1'b1, 1'b0, 16'habcd, 8'h9e, 1'b0};

    reset = 1'b1; cpu_a = '0; cpu_do = '0; cpu_idle(); cpu_busak_n = 1'b1;
    dma_req = 1'b0; dma_valid = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_busrq_n", cpu_busrq_n, 1);
    check("rst_ready", dma_ready, 0);
    check("rst_rvalid", dma_rvalid, 0);
    check("rst_grant", dma_grant, 0);
    check("rst_mem_we", mem_we, 0);
    tick();
    reset = 1'b0;

    // CPU-owned port: combinational pass-through, busak_n low is ignored.
    for (int i = 0; i < 6; i++) begin
      cpu_a = vt[i].a; cpu_do = vt[i].d;
      cpu_mreq_n = vt[i].mreq_n; cpu_wr_n = vt[i].wr_n; cpu_busak_n = vt[i].busak_n;
      @(negedge clk);
      $display("vec %0d: a=%h d=%h mreq_n=%b wr_n=%b -> mem_addr=%h mem_wdata=%h mem_we=%b",
               i, vt[i].a, vt[i].d, vt[i].mreq_n, vt[i].wr_n, mem_addr, mem_wdata, mem_we);
      check("vec_addr", mem_addr, vt[i].exp_addr);
      check("vec_wdata", mem_wdata, vt[i].exp_wdata);
      check("vec_we", mem_we, vt[i].exp_we);
      check("vec_busrq_n", cpu_busrq_n, 1);
      check("vec_grant", dma_grant, 0);
      tick();
    end
    cpu_busak_n = 1'b1;
    cpu_a = 16'hef75; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b1;
    tick();
    @(negedge clk);
    check("cpu_di_ef75", cpu_di, 8'h17);
    check("mem_ef75_cpu", mem[16'hef75], 8'h17);
    check("mem_0003_cpu", mem[16'h0003], 8'h33);
    tick();
    cpu_idle();

    // Request handshake.
    dma_req = 1'b1;
    @(negedge clk);
    check("busrq_before_edge", cpu_busrq_n, 1);
    tick();
    @(negedge clk);
    check("busrq_fall", cpu_busrq_n, 0);
    check("req_ready_low", dma_ready, 0);
    tick();
    cpu_a = 16'h0100; cpu_do = 8'h77; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    @(negedge clk);
    check("req_cpu_we_fwd", mem_we, 1);
    tick();
    cpu_idle();
    cpu_busak_n = 1'b0;
    @(negedge clk);
    check("ready_before_busak_edge", dma_ready, 0);
    tick();
    @(negedge clk);
    check("ready_rise", dma_ready, 1);
    check("grant_rise", dma_grant, 1);
    tick();
    cpu_a = 16'h0200; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; dma_addr = 16'h4444;
    @(negedge clk);
    check("dma_blocks_cpu_we", mem_we, 0);
    check("dma_port_addr", mem_addr, 16'h4444);
    tick();
    cpu_idle();

    // 4-beat write burst, then a read mid-burst and a read on the last cycle.
    for (int i = 0; i < 4; i++) begin
      dma_beat(1'b1, 16'hef75 + 16'(i), 8'h17 + 8'(i));
      @(negedge clk);
      $display("wr beat %0d: addr=%h data=%h mem_we=%b", i, mem_addr, mem_wdata, mem_we);
      check("burst_we", mem_we, 1);
      check("burst_addr", mem_addr, 16'hef75 + 16'(i));
      check("burst_wdata", mem_wdata, 8'h17 + 8'(i));
      tick();
    end
    dma_beat(1'b0, 16'hef76, 8'h00);
    @(negedge clk);
    check("rd1_ready", dma_ready, 1);
    rq.push_back('{8'h18, cyc});
    $display("rd beat: addr=ef76 expect 18 at cycle %0d", cyc + 1);
    tick();
    dma_beat(1'b0, 16'h0003, 8'h00);
    dma_req = 1'b0;
    @(negedge clk);
    check("rd2_ready", dma_ready, 1);
    rq.push_back('{8'h33, cyc});
    $display("rd beat: addr=0003 expect 33 at cycle %0d", cyc + 1);
    tick();
    dma_beat(1'b1, 16'h5555, 8'hee);
    @(negedge clk);
    check("rel_busrq_n", cpu_busrq_n, 1);
    check("rel_ready", dma_ready, 0);
    check("rel_grant", dma_grant, 0);
    check("rel_mem_we", mem_we, 0);
    tick();
    dma_valid = 1'b0;
    cpu_busak_n = 1'b1;
    tick();
    cpu_a = 16'h0300;
    @(negedge clk);
    check("cpu_back_addr", mem_addr, 16'h0300);
    for (int i = 0; i < 4; i++) check("mem_burst", mem[16'hef75 + 16'(i)], 8'h17 + 8'(i));
    check("mem_5555_untouched", mem[16'h5555], 8'h00);

    // Forced release after MAX_BURST, holdoff, re-request, tail of the queue.
    repeat (HO + 2) tick();
    dma_req = 1'b1;
    tick();
    cpu_busak_n = 1'b0;
    tick();
    idx = 0;
    for (int c = 0; c < 40 && idx < 20; c++) begin
      dma_beat(1'b1, 16'h1000 + 16'(idx), 8'(idx) ^ 8'h5a);
      @(negedge clk);
      if (!dma_ready) break;
      idx++;
      tick();
    end
    $display("first grant accepted %0d beats", idx);
    check("maxburst_beats", idx, MB);
    check("maxburst_busrq_n", cpu_busrq_n, 1);
    check("maxburst_mem_we", mem_we, 0);
    tick();
    dma_valid = 1'b0;
    cpu_busak_n = 1'b1;
    @(posedge clk);
    #1;
    hcnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!cpu_busrq_n) break;
      hcnt++;
    end
    $display("CPU held bus %0d cycles before re-request", hcnt);
    check("holdoff_cycles", hcnt, HO + 1);
    @(posedge clk);
    #1;
    cpu_busak_n = 1'b0;
    tick();
    for (int c = 0; c < 10 && idx < 20; c++) begin
      dma_beat(1'b1, 16'h1000 + 16'(idx), 8'(idx) ^ 8'h5a);
      @(negedge clk);
      check("burst2_ready", dma_ready, 1);
      idx++;
      tick();
    end
    dma_valid = 1'b0;
    dma_req = 1'b0;
    tick();
    @(negedge clk);
    check("burst2_release", cpu_busrq_n, 1);
    tick();
    cpu_busak_n = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) check("mem_queue", mem[16'h1000 + 16'(i)], 8'(i) ^ 8'h5a);

    // Reset during beat 2 of a write burst.
    repeat (HO + 2) tick();
    dma_req = 1'b1;
    tick();
    cpu_busak_n = 1'b0;
    tick();
    dma_beat(1'b1, 16'h2000, 8'hc3);
    @(negedge clk);
    check("rstb_beat1_we", mem_we, 1);
    tick();
    dma_beat(1'b1, 16'h2001, 8'ha5);
    reset = 1'b1;
    @(negedge clk);
    check("rstb_beat2_no_we", mem_we, 0);
    tick();
    reset = 1'b0; dma_req = 1'b0; dma_valid = 1'b0; cpu_busak_n = 1'b1;
    cpu_a = 16'h3000; cpu_do = 8'h66; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    @(negedge clk);
    check("rstb_busrq_n", cpu_busrq_n, 1);
    check("rstb_grant", dma_grant, 0);
    check("rstb_ready", dma_ready, 0);
    check("rstb_rvalid", dma_rvalid, 0);
    check("rstb_cpu_we", mem_we, 1);
    check("rstb_cpu_addr", mem_addr, 16'h3000);
    tick();
    cpu_idle();
    tick();
    check("rstb_mem_2000", mem[16'h2000], 8'hc3);
    check("rstb_mem_2001", mem[16'h2001], 8'h00);
    check("rstb_mem_3000", mem[16'h3000], 8'h66);
    check("rd_queue_empty", rq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
